// File: rtl/spi_rx_fifo.sv
// Receive byte buffer behind the SPI block: captures every incoming byte (no backpressure),
// presents bytes first-word-fall-through to the host, and flags dropped writes.
module spi_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow,
    input  logic                         overflow_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;

    logic push;
    logic pop;
    logic drop;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AF_C);
    assign rd_valid    = !empty;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign rd_data     = mem[rd_ptr];

    assign pop  = rd_valid && rd_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push = wr_valid && (!full || pop);
    assign drop = wr_valid && full && !pop;

    // Storage is intentionally not reset; rd_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Setting takes priority over a simultaneous clear so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

endmodule
